// File: rtl/pattern_pkg.sv
// pattern_pkg: shared pattern constant, generator FSM states and byte-select helper
package pattern_pkg;
    localparam logic [31:0] CORRECT_PATTERN = 32'hABCD0102;
    localparam int BYTE_IDX_W = 2;
    typedef enum logic [1:0] {IDLE, SEND, DONE} gen_state_t;
    function automatic logic [7:0] pattern_byte(input logic [BYTE_IDX_W-1:0] idx);
        return CORRECT_PATTERN[8*idx +: 8];
    endfunction
endpackage

// File: rtl/pattern_generator.sv
// pattern_generator: byte-serial repeated-pattern transmitter over a valid/ready stream.
// Optional PATTERN_GEN_ERR_INJECT_EN adds err_inject, corrupting the final byte of a burst.
module pattern_generator
    import pattern_pkg::*;
#(
    parameter int Repetitive_width = 8,
    parameter int output_width = 8
) (
    input  logic                        CLK,
    input  logic                        RST,
    input  logic                        start,
    input  logic                        abort,
    input  logic [Repetitive_width-1:0] N,
    input  logic                        pattern_ready,
`ifdef PATTERN_GEN_ERR_INJECT_EN
    input  logic                        err_inject,
`endif
    output logic [output_width-1:0]     pattern,
    output logic                        pattern_valid,
    output logic                        pattern_check,
    output logic                        busy,
    output logic                        done
);
    localparam logic [Repetitive_width-1:0] ONE = 1;
    gen_state_t state;
    logic [BYTE_IDX_W-1:0] byte_idx, next_idx;
    logic [Repetitive_width-1:0] rep_cnt, n_reg;
    logic accept, last_rep;
    logic [7:0] next_byte;
`ifdef PATTERN_GEN_ERR_INJECT_EN
    logic err_reg;
`endif
    always_comb begin
        accept = pattern_valid && pattern_ready;
        last_rep = rep_cnt == n_reg - ONE;
        next_idx = byte_idx + 1'b1;
`ifdef PATTERN_GEN_ERR_INJECT_EN
        next_byte = (err_reg && last_rep && next_idx == 2'd3) ? 8'h54 : pattern_byte(next_idx);
`else
        next_byte = pattern_byte(next_idx);
`endif
    end
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= IDLE;
            byte_idx <= '0;
            rep_cnt <= '0;
            n_reg <= '0;
            pattern <= '0;
            pattern_valid <= 1'b0;
            pattern_check <= 1'b0;
            busy <= 1'b0;
            done <= 1'b0;
`ifdef PATTERN_GEN_ERR_INJECT_EN
            err_reg <= 1'b0;
`endif
        end else if (abort) begin
            // abort beats start and a coincident final accept: no done/check pulse
            state <= IDLE;
            pattern <= '0;
            pattern_valid <= 1'b0;
            pattern_check <= 1'b0;
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= start && N == '0;
                    pattern_check <= 1'b0;
                    if (start && N != '0) begin
                        state <= SEND;
                        n_reg <= N;
                        byte_idx <= '0;
                        rep_cnt <= '0;
                        pattern <= output_width'(pattern_byte('0));
                        pattern_valid <= 1'b1;
                        busy <= 1'b1;
`ifdef PATTERN_GEN_ERR_INJECT_EN
                        err_reg <= err_inject;
`endif
                    end
                end
                SEND: begin
                    if (accept) begin
                        byte_idx <= next_idx;
                        if (byte_idx == 2'd3)
                            rep_cnt <= rep_cnt + ONE;
                        if (byte_idx == 2'd3 && last_rep) begin
                            state <= DONE;
                            pattern <= '0;
                            pattern_valid <= 1'b0;
                            pattern_check <= 1'b1;
                            done <= 1'b1;
                        end else
                            pattern <= output_width'(next_byte);
                    end
                end
                DONE: begin
                    state <= IDLE;
                    pattern_check <= 1'b0;
                    done <= 1'b0;
                    busy <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_pattern_generator.sv
// tb_pattern_generator: directed self-checking bench for pattern_generator
module tb_pattern_generator;
    logic CLK = 0, RST = 1, start = 0, abort = 0, pattern_ready = 1;
    logic [7:0] N = 0;
    logic [7:0] pattern;
    logic pattern_valid, pattern_check, busy, done;
`ifdef PATTERN_GEN_ERR_INJECT_EN
    logic err_inject = 0;
`endif
    int checks = 0, failures = 0;
    logic [7:0] pat [4] = '{8'h02, 8'h01, 8'hCD, 8'hAB};

    always #5 CLK = ~CLK;

    pattern_generator #(.Repetitive_width(8), .output_width(8)) dut (
        .CLK(CLK), .RST(RST), .start(start), .abort(abort), .N(N),
        .pattern_ready(pattern_ready),
`ifdef PATTERN_GEN_ERR_INJECT_EN
        .err_inject(err_inject),
`endif
        .pattern(pattern), .pattern_valid(pattern_valid),
        .pattern_check(pattern_check), .busy(busy), .done(done)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step;
        @(posedge CLK);
        #1;
    endtask

    // flags packed as {valid, check, done, busy}
    function automatic logic [3:0] flags;
        return {pattern_valid, pattern_check, done, busy};
    endfunction

    task automatic launch(input logic [7:0] n);
        N = n;
        start = 1;
        step;
        start = 0;
    endtask

    // full-rate burst: expects 4*n bytes, then a done/check cycle, then idle
    task automatic run_burst(input string tag, input int n, input logic [7:0] last);
        for (int i = 0; i < 4 * n; i++) begin
            check({tag, "_byte"}, {pattern_valid, pattern},
                  {1'b1, (i == 4 * n - 1) ? last : pat[i % 4]});
            step;
        end
        check({tag, "_done"}, {flags(), pattern}, {4'b0111, 8'h00});
        step;
        check({tag, "_idle"}, flags(), 4'b0000);
    endtask

    initial begin
        step;
        step;
        check("reset", {flags(), pattern}, 12'h000);
        RST = 0;
        step;
        check("idle_after_reset", flags(), 4'b0000);

        // 1: N=3 full rate, 12 bytes
        launch(8'd3);
        run_burst("t1", 3, 8'hAB);

        // 2: N=1 with backpressure on CD
        launch(8'd1);
        check("t2_b0", pattern, 8'h02);
        step;
        check("t2_b1", pattern, 8'h01);
        step;
        check("t2_cd0", {pattern_valid, pattern}, {1'b1, 8'hCD});
        pattern_ready = 0;
        for (int i = 1; i < 4; i++) begin
            step;
            check("t2_cd_hold", {pattern_valid, pattern}, {1'b1, 8'hCD});
        end
        pattern_ready = 1;
        step;
        check("t2_ab", {pattern_valid, pattern}, {1'b1, 8'hAB});
        step;
        check("t2_done", flags(), 4'b0111);
        step;
        check("t2_idle", flags(), 4'b0000);

        // 3: N=0 gives a bare done pulse
        launch(8'd0);
        check("t3_done", {flags(), pattern}, {4'b0010, 8'h00});
        step;
        check("t3_idle", flags(), 4'b0000);

        // 4: N=5, stray start and N change ignored, abort in rep 2
        launch(8'd5);
        N = 8'd1;
        for (int k = 0; k < 6; k++) begin
            check("t4_byte", {pattern_valid, pattern}, {1'b1, pat[k % 4]});
            start = (k == 3);
            abort = (k == 5);
            step;
        end
        start = 0;
        abort = 0;
        check("t4_abort", {flags(), pattern}, {4'b0000, 8'h00});
        step;
        check("t4_no_done", flags(), 4'b0000);
        launch(8'd5);
        N = 8'd2;
        run_burst("t4_rerun", 5, 8'hAB);

        // 5: async reset mid-burst
        launch(8'd2);
        step;
        check("t5_b1", pattern, 8'h01);
        #2 RST = 1;
        #1;
        check("t5_async_clear", {flags(), pattern}, 12'h000);
        step;
        RST = 0;
        step;
        check("t5_idle", {flags(), pattern}, 12'h000);

`ifdef PATTERN_GEN_ERR_INJECT_EN
        // 6: error injection corrupts only the final byte
        err_inject = 1;
        launch(8'd2);
        err_inject = 0;
        run_burst("t6_err", 2, 8'h54);
        launch(8'd2);
        run_burst("t6_ok", 2, 8'hAB);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
